// File: rtl/shifter_if.sv
// Bus bundle between the datapath and the shifter-operand generator.
// Carries the instruction word, the Rm read value, the current C flag and
// the capture enable toward the shifter, plus its registered operand/offset
// and carry-out back toward the ALU.
//   master : drives IR, RM, CIN, ENABLE; observes OPERAND, COUT
//   slave  : observes IR, RM, CIN, ENABLE; drives OPERAND, COUT
interface shifter_if;
    logic [31:0] IR;
    logic [31:0] RM;
    logic        CIN;
    logic        ENABLE;
    logic [31:0] OPERAND;
    logic        COUT;

    modport master (
        output IR, RM, CIN, ENABLE,
        input  OPERAND, COUT
    );

    modport slave (
        input  IR, RM, CIN, ENABLE,
        output OPERAND, COUT
    );
endinterface

// File: rtl/shifter.sv
// Registered ARM shifter-operand / address-offset generator.
// Decodes the instruction class bits IR[27:25], IR[7] and IR[4] and produces
// the 32-bit second ALU operand (or load/store offset) plus the shifter
// carry-out. Results are captured on the rising edge of CLK while ENABLE is
// high; RESET clears both outputs asynchronously.
//   CLK        : system clock, rising-edge active
//   RESET      : asynchronous active-high reset
//   bus.IR     : current instruction word
//   bus.RM     : value of register Rm
//   bus.CIN    : current C flag
//   bus.ENABLE : capture enable
//   bus.OPERAND: registered operand / offset
//   bus.COUT   : registered shifter carry-out
module shifter (
    input  logic     CLK,
    input  logic     RESET,
    shifter_if.slave bus
);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Condition field is not used by operand generation.
    logic unused_cond;
    assign unused_cond = ^bus.IR[31:28];

    // Shift-by-immediate result, shared by data-processing and scaled
    // register addressing.
    logic [31:0] sh_res;
    logic        sh_c;
    logic [4:0]  sh_n;
    shift_t      sh_type;
    logic [5:0]  sh_inv;

    always_comb begin
        sh_n    = bus.IR[11:7];
        sh_type = shift_t'(bus.IR[6:5]);
        sh_inv  = 6'd32 - {1'b0, sh_n};
        sh_res  = bus.RM;
        sh_c    = bus.CIN;
        unique case (sh_type)
            SH_LSL: begin
                if (sh_n != 5'd0) begin
                    sh_res = bus.RM << sh_n;
                    sh_c   = bus.RM[sh_inv[4:0]];
                end
            end
            SH_LSR: begin
                if (sh_n == 5'd0) begin
                    // LSR #0 encodes LSR #32
                    sh_res = '0;
                    sh_c   = bus.RM[31];
                end else begin
                    sh_res = bus.RM >> sh_n;
                    sh_c   = bus.RM[sh_n - 5'd1];
                end
            end
            SH_ASR: begin
                if (sh_n == 5'd0) begin
                    // ASR #0 encodes ASR #32
                    sh_res = {32{bus.RM[31]}};
                    sh_c   = bus.RM[31];
                end else begin
                    sh_res = $unsigned($signed(bus.RM) >>> sh_n);
                    sh_c   = bus.RM[sh_n - 5'd1];
                end
            end
            SH_ROR: begin
                if (sh_n == 5'd0) begin
                    // ROR #0 encodes RRX: C rotates in at the top
                    sh_res = {bus.CIN, bus.RM[31:1]};
                    sh_c   = bus.RM[0];
                end else begin
                    sh_res = (bus.RM >> sh_n) | (bus.RM << sh_inv);
                    sh_c   = bus.RM[sh_n - 5'd1];
                end
            end
            default: begin
                sh_res = bus.RM;
                sh_c   = bus.CIN;
            end
        endcase
    end

    // Rotated 8-bit immediate.
    logic [31:0] imm_res;
    logic        imm_c;
    logic [4:0]  imm_rot;
    logic [31:0] imm_base;

    always_comb begin
        imm_rot  = {bus.IR[11:8], 1'b0};
        imm_base = {24'd0, bus.IR[7:0]};
        imm_res  = imm_base;
        imm_c    = bus.CIN;
        if (imm_rot != 5'd0) begin
            imm_res = (imm_base >> imm_rot) | (imm_base << (6'd32 - {1'b0, imm_rot}));
            imm_c   = imm_res[31];
        end
    end

    // Register-list population count for load/store multiple.
    logic [4:0] reg_cnt;

    always_comb begin
        reg_cnt = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            reg_cnt = reg_cnt + {4'd0, bus.IR[i]};
        end
    end

    // Class decode.
    logic [31:0] next_op;
    logic        next_c;

    always_comb begin
        next_op = bus.RM;
        next_c  = bus.CIN;
        unique case (bus.IR[27:25])
            3'b000: begin
                if (!bus.IR[4]) begin
                    next_op = sh_res;
                    next_c  = sh_c;
                end else if (bus.IR[7]) begin
                    next_op = {24'd0, bus.IR[11:8], bus.IR[3:0]};
                end else begin
                    // Register-specified shift: no Rs path, pass Rm through
                    next_op = bus.RM;
                end
            end
            3'b001: begin
                next_op = imm_res;
                next_c  = imm_c;
            end
            3'b010: next_op = {20'd0, bus.IR[11:0]};
            3'b011: begin
                next_op = sh_res;
                next_c  = sh_c;
            end
            3'b100: next_op = {25'd0, reg_cnt, 2'b00};
            3'b101: next_op = {{6{bus.IR[23]}}, bus.IR[23:0], 2'b00};
            default: next_op = bus.RM;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.OPERAND <= '0;
            bus.COUT    <= 1'b0;
        end else if (bus.ENABLE) begin
            bus.OPERAND <= next_op;
            bus.COUT    <= next_c;
        end
    end

endmodule

// File: tb/tb_shifter.sv
// Directed self-checking bench for the shifter operand generator.
// Expected results are queued when stimulus is driven and popped one cycle
// later when the registered outputs appear.
module tb_shifter;

    logic CLK;
    logic RESET;

    shifter_if bus ();

    shifter dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] op;
        logic        c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] op, input logic c,
                         input logic [31:0] eop, input logic ec);
        checks++;
        assert (op === eop && c === ec)
        else begin
            errors++;
            $error("FAIL %s: got OPERAND=%08h COUT=%b, expected OPERAND=%08h COUT=%b",
                   tag, op, c, eop, ec);
        end
    endtask

    // Drive one enabled capture, queue its expectation, compare after the edge.
    task automatic step(input string tag, input logic [31:0] ir, input logic [31:0] rm,
                        input logic cin, input logic [31:0] eop, input logic ec);
        exp_t e;
        @(negedge CLK);
        bus.IR     = ir;
        bus.RM     = rm;
        bus.CIN    = cin;
        bus.ENABLE = 1'b1;
        e.tag = tag; e.op = eop; e.c = ec;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, bus.OPERAND, bus.COUT, e.op, e.c);
        end
    endtask

    initial begin
        RESET      = 1'b1;
        bus.IR     = '0;
        bus.RM     = '0;
        bus.CIN    = 1'b0;
        bus.ENABLE = 1'b1;
        #1;
        check("reset_state", bus.OPERAND, bus.COUT, 32'h0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        // Rotated immediate
        step("imm_rot2",      32'h52901120, 32'd35, 1'b0, 32'h00000008, 1'b0);
        step("imm_rot0_cin",  32'h52901020, 32'd35, 1'b1, 32'h00000020, 1'b1);
        step("imm_rot_c1",    32'hE3A004FF, 32'd0,  1'b0, 32'hFF000000, 1'b1);

        // Shift by immediate
        step("lsl3",          32'h50901188, 32'd35, 1'b0, 32'd280, 1'b0);
        step("lsl0",          32'hE1A00000, 32'h12345678, 1'b1, 32'h12345678, 1'b1);
        step("lsl2_c",        32'hE1A00100, 32'h40000000, 1'b0, 32'h0, 1'b1);
        step("lsr32",         32'hE09A102C, 32'd35, 1'b0, 32'h0, 1'b0);
        step("lsr32_c",       32'hE09A102C, 32'h80000001, 1'b0, 32'h0, 1'b1);
        step("lsr1",          32'hE1A000A0, 32'h00000003, 1'b0, 32'h1, 1'b1);
        step("rrx",           32'hE1A00060, 32'h80000001, 1'b1, 32'hC0000000, 1'b1);
        step("asr32",         32'hE1A00040, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1);
        step("ror8",          32'hE1A00460, 32'h12345678, 1'b1, 32'h78123456, 1'b0);
        step("regshift_rm",   32'hE1A00110, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1);

        // Address offsets
        step("am2_imm",       32'hE5565014, 32'd99, 1'b0, 32'd20, 1'b0);
        step("am3_imm",       32'hE1E65BDE, 32'd99, 1'b0, 32'h000000BE, 1'b0);
        step("am2_scaled",    32'hE7912240, 32'h80000018, 1'b0, 32'hF8000001, 1'b1);
        step("ldm6",          32'hE8B31782, 32'd99, 1'b1, 32'd24, 1'b1);
        step("ldm0",          32'hE8900000, 32'd99, 1'b0, 32'd0, 1'b0);
        step("ldm16",         32'hE890FFFF, 32'd99, 1'b0, 32'd64, 1'b0);
        step("class110_rm",   32'hEC000000, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF, 1'b0);

        // Mid-run asynchronous reset with ENABLE still high
        step("pre_reset",     32'hE1A00060, 32'h80000001, 1'b1, 32'hC0000000, 1'b1);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset", bus.OPERAND, bus.COUT, 32'h0, 1'b0);
        @(posedge CLK);
        #1;
        check("reset_over_enable", bus.OPERAND, bus.COUT, 32'h0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        step("post_reset",    32'h50901188, 32'd35, 1'b1, 32'd280, 1'b0);

        // Branch then hold
        step("branch_neg",    32'hEAFFFFFF, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b1);
        @(negedge CLK);
        bus.ENABLE = 1'b0;
        bus.IR     = 32'hE5565014;
        bus.RM     = 32'h55555555;
        bus.CIN    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("hold_%0d", k), bus.OPERAND, bus.COUT, 32'hFFFFFFFC, 1'b1);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
